// File: rtl/block_memory.sv
// block_memory: DEPTH x WORD_W array moving BLOCK_WORDS-word blocks, one word per cycle, over
// valid/ready request/response channels. Define BLOCK_MEMORY_INIT_EN to zero the array after reset.
module block_memory #(
   parameter  int WORD_W      = 32,
   parameter  int DEPTH       = 512,
   parameter  int BLOCK_WORDS = 16,
   localparam int AW          = $clog2(DEPTH)
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          req_valid_i,
   output logic                          req_ready_o,
   input  logic                          req_write_i,
   input  logic [AW-1:0]                 req_addr_i,
   input  logic [WORD_W*BLOCK_WORDS-1:0] req_wdata_i,
   input  logic [BLOCK_WORDS-1:0]        req_wmask_i,
   output logic                          resp_valid_o,
   input  logic                          resp_ready_i,
   output logic                          resp_write_o,
   output logic [WORD_W*BLOCK_WORDS-1:0] resp_rdata_o
);
   localparam int KW = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
   localparam int DW = WORD_W * BLOCK_WORDS;
   localparam logic [AW-1:0] LAST_WORD = AW'(BLOCK_WORDS - 1);

   typedef enum logic [1:0] {
      S_INIT = 2'd0,
      S_IDLE = 2'd1,
      S_XFER = 2'd2,
      S_RESP = 2'd3
   } state_t;

`ifdef BLOCK_MEMORY_INIT_EN
   localparam state_t        RST_STATE = S_INIT;
   localparam logic          RST_READY = 1'b0;
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
`else
   localparam state_t        RST_STATE = S_IDLE;
   localparam logic          RST_READY = 1'b1;
`endif

   state_t                 state_q;
   logic [AW-1:0]          cnt_q;
   logic [AW-1:0]          cnt_d;
   logic [AW-1:0]          addr_q;
   logic                   write_q;
   logic [DW-1:0]          wdata_q;
   logic [BLOCK_WORDS-1:0] wmask_q;
   logic                   req_ready_q;
   logic                   resp_valid_q;
   logic                   resp_write_q;
   logic [DW-1:0]          rdata_q;

   logic [WORD_W-1:0]      mem [DEPTH];
   logic [KW-1:0]          word_s;
   logic                   mem_we_s;
   logic [AW-1:0]          mem_addr_s;
   logic [WORD_W-1:0]      mem_wdata_s;

   assign word_s = cnt_q[KW-1:0];
   assign cnt_d  = cnt_q + AW'(1);

   // Array port control: the INIT sweep addresses by counter, a transfer by base + counter.
   always_comb begin
      mem_we_s    = 1'b0;
      mem_addr_s  = addr_q + cnt_q;
      mem_wdata_s = wdata_q[word_s*WORD_W +: WORD_W];
      case (state_q)
`ifdef BLOCK_MEMORY_INIT_EN
         S_INIT: begin
            mem_we_s    = !rst_i;
            mem_addr_s  = cnt_q;
            mem_wdata_s = '0;
         end
`endif
         S_XFER:  mem_we_s = write_q && wmask_q[word_s] && !rst_i;
         default: mem_we_s = 1'b0;
      endcase
   end

   // Array write port has no reset so contents survive an abandoned transfer.
   always_ff @(posedge clk_i) begin
      if (mem_we_s) begin
         mem[mem_addr_s] <= mem_wdata_s;
      end
   end

   // Control FSM with registered channel outputs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= RST_STATE;
         cnt_q        <= '0;
         addr_q       <= '0;
         write_q      <= 1'b0;
         wdata_q      <= '0;
         wmask_q      <= '0;
         req_ready_q  <= RST_READY;
         resp_valid_q <= 1'b0;
         resp_write_q <= 1'b0;
         rdata_q      <= '0;
      end else begin
         case (state_q)
`ifdef BLOCK_MEMORY_INIT_EN
            S_INIT: begin
               if (cnt_q == LAST_ADDR) begin
                  state_q     <= S_IDLE;
                  cnt_q       <= '0;
                  req_ready_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
`endif
            S_IDLE: begin
               if (req_valid_i && req_ready_q) begin
                  state_q     <= S_XFER;
                  cnt_q       <= '0;
                  addr_q      <= req_addr_i;
                  write_q     <= req_write_i;
                  wdata_q     <= req_wdata_i;
                  wmask_q     <= req_wmask_i;
                  req_ready_q <= 1'b0;
               end
            end
            S_XFER: begin
               // The buffer stays all-zero during writes, which is what a write response carries.
               if (!write_q) begin
                  rdata_q[word_s*WORD_W +: WORD_W] <= mem[mem_addr_s];
               end
               if (cnt_q == LAST_WORD) begin
                  state_q      <= S_RESP;
                  resp_valid_q <= 1'b1;
                  resp_write_q <= write_q;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            S_RESP: begin
               if (resp_valid_q && resp_ready_i) begin
                  state_q      <= S_IDLE;
                  resp_valid_q <= 1'b0;
                  resp_write_q <= 1'b0;
                  rdata_q      <= '0;
                  req_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q      <= S_IDLE;
               cnt_q        <= '0;
               req_ready_q  <= 1'b1;
               resp_valid_q <= 1'b0;
               resp_write_q <= 1'b0;
               rdata_q      <= '0;
            end
         endcase
      end
   end

   assign req_ready_o  = req_ready_q;
   assign resp_valid_o = resp_valid_q;
   assign resp_write_o = resp_write_q;
   assign resp_rdata_o = rdata_q;

endmodule

// File: tb/tb_block_memory.sv
// Bench for block_memory: directed block scenarios plus random traffic checked every cycle
// against an array-based model of the block store and its transfer timing.
module tb_block_memory;
`ifdef BLOCK_MEMORY_INIT_EN
   localparam int DEPTH = 64;
   localparam int BW = 4;
   localparam bit INIT_EN = 1'b1;
`else
   localparam int DEPTH = 512;
   localparam int BW = 16;
   localparam bit INIT_EN = 1'b0;
`endif
   localparam int WW  = 32;
   localparam int AW  = $clog2(DEPTH);
   localparam int DW  = WW * BW;
   localparam int TMO = DEPTH + 100;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid, req_ready, req_write;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic [BW-1:0] req_wmask;
   logic          resp_valid, resp_ready, resp_write;
   logic [DW-1:0] resp_rdata;

   block_memory #(.WORD_W(WW), .DEPTH(DEPTH), .BLOCK_WORDS(BW)) dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wmask_i(req_wmask),
      .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
      .resp_write_o(resp_write), .resp_rdata_o(resp_rdata)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;
   int cyc = 0;
   int acc_cyc = 0;
   int hs_cyc = 0;

   // reference model: word array, known-word flags, one in-flight transaction
   logic [WW-1:0] mdl [DEPTH];
   bit            known [DEPTH];
   bit            pending = 1'b0;
   bit            post_hs = 1'b0;
   int            e = 0;
   int            init_left = 0;
   logic          m_write;
   int            m_addr;
   logic [DW-1:0] m_wdata;
   logic [BW-1:0] m_mask;
   logic [WW-1:0] exp_word [BW];
   bit            exp_known [BW];

   task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, want %h", name, act, exp);
   endtask

   task automatic finish_run();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   endtask

   function automatic logic [WW-1:0] wd(input logic [DW-1:0] v, input int k);
      return v[k*WW +: WW];
   endfunction

   task automatic check_block();
      int bad;
      bad = -1;
      for (int k = 0; k < BW; k++)
         if (exp_known[k] && wd(resp_rdata, k) !== exp_word[k] && bad < 0) bad = k;
      n_total++;
      if (bad < 0) n_pass++;
      else $display("FAIL resp_rdata word %0d: got %h, want %h", bad, wd(resp_rdata, bad), exp_word[bad]);
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // compare process: all outputs checked at every falling edge
   initial forever begin
      @(negedge clk);
      if (rst) begin
         pending = 1'b0;
         post_hs = 1'b0;
         init_left = INIT_EN ? DEPTH : 0;
         check("rst_req_ready", WW'(req_ready), WW'(!INIT_EN));
         check("rst_resp_valid", WW'(resp_valid), 32'd0);
         check("rst_rdata_zero", WW'(resp_rdata == '0), 32'd1);
      end else begin
         if (init_left > 0) begin
            init_left--;
            check("init_req_ready", WW'(req_ready), WW'(init_left == 0));
            if (init_left == 0)
               for (int a = 0; a < DEPTH; a++) begin mdl[a] = '0; known[a] = 1'b1; end
         end else if (post_hs) begin
            post_hs = 1'b0;
            check("post_hs_req_ready", WW'(req_ready), 32'd1);
            check("post_hs_resp_valid", WW'(resp_valid), 32'd0);
            check("post_hs_rdata_zero", WW'(resp_rdata == '0), 32'd1);
         end else if (pending) begin
            e++;
            if (e >= 1 && e <= BW && m_write && m_mask[e-1]) begin
               mdl[(m_addr + e - 1) % DEPTH] = wd(m_wdata, e - 1);
               known[(m_addr + e - 1) % DEPTH] = 1'b1;
            end
            check("busy_req_ready", WW'(req_ready), 32'd0);
            if (e < BW) begin
               check("xfer_resp_valid", WW'(resp_valid), 32'd0);
            end else begin
               check("resp_valid", WW'(resp_valid), 32'd1);
               check("resp_write", WW'(resp_write), WW'(m_write));
               check_block();
               if (resp_ready) begin pending = 1'b0; post_hs = 1'b1; end
            end
         end else begin
            check("idle_req_ready", WW'(req_ready), 32'd1);
            check("idle_resp_valid", WW'(resp_valid), 32'd0);
         end
         if (init_left == 0 && !pending && req_valid && req_ready) begin
            pending = 1'b1;
            e = -1;
            m_write = req_write;
            m_addr = int'(req_addr);
            m_wdata = req_wdata;
            m_mask = req_wmask;
            for (int k = 0; k < BW; k++) begin
               exp_word[k]  = req_write ? '0 : mdl[(m_addr + k) % DEPTH];
               exp_known[k] = req_write ? 1'b1 : known[(m_addr + k) % DEPTH];
            end
         end
      end
   end

   task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [BW-1:0] m);
      int t;
      t = 0;
      req_write = w; req_addr = a; req_wdata = d; req_wmask = m; req_valid = 1'b1;
      @(negedge clk);
      while (!req_ready && t < TMO) begin @(negedge clk); t++; end
      check("req_accept_in_time", WW'(req_ready), 32'd1);
      if (!req_ready) finish_run();
      @(posedge clk); #1;
      acc_cyc = cyc;
      req_valid = 1'b0;
   endtask

   // hold < 0: resp_ready raised before the response appears
   task automatic collect(input int hold, output logic [DW-1:0] rd, output logic wr, output int lat);
      int t;
      t = 0;
      if (hold < 0) resp_ready = 1'b1;
      @(negedge clk);
      while (!resp_valid && t < TMO) begin @(negedge clk); t++; end
      check("resp_in_time", WW'(resp_valid), 32'd1);
      if (!resp_valid) finish_run();
      lat = cyc - acc_cyc;
      rd = resp_rdata;
      wr = resp_write;
      if (hold >= 0) begin
         repeat (hold) @(posedge clk);
         @(posedge clk); #1;
         resp_ready = 1'b1;
      end
      @(posedge clk); #1;
      hs_cyc = cyc;
      resp_ready = 1'b0;
   endtask

   initial begin
      #2000000;
      n_total++;
      $display("FAIL watchdog: got timeout, want completion");
      finish_run();
   end

   initial begin
      logic [DW-1:0] d, rd;
      logic          wr;
      int            lat, a1, n, g;
      rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
      req_wdata = '0; req_wmask = '0; resp_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1 rst = 1'b0;
`ifdef BLOCK_MEMORY_INIT_EN
      n = 0;
      do begin @(negedge clk); n++; end while (!req_ready && n < TMO);
      check("init_ready_low_cycles", WW'(n), WW'(DEPTH));
      @(posedge clk); #1;
      issue(1'b0, AW'(32'h3C), '0, '0);
      collect(0, rd, wr, lat);
      for (int i = 0; i < BW; i++) check("init_read_zero", wd(rd, i), 32'h0);
`else
      @(posedge clk); #1;
      // write then read
      for (int i = 0; i < BW; i++) d[i*WW +: WW] = 32'hA000_0000 + WW'(i);
      issue(1'b1, AW'(32'h020), d, '1);
      collect(0, rd, wr, lat);
      check("wr_latency", WW'(lat), WW'(BW));
      check("wr_resp_write", WW'(wr), 32'd1);
      issue(1'b0, AW'(32'h020), '0, '0);
      collect(0, rd, wr, lat);
      check("rd_latency", WW'(lat), WW'(BW));
      check("rd_resp_write", WW'(wr), 32'd0);
      for (int i = 0; i < BW; i++) check("rd_word", wd(rd, i), 32'hA000_0000 + WW'(i));
      // masked write, response consumed on the first RESP edge, back-to-back read
      for (int i = 0; i < BW; i++) d[i*WW +: WW] = 32'hFFFF_FFFF;
      issue(1'b1, AW'(32'h020), d, BW'(32'h0000_00F0));
      a1 = acc_cyc;
      collect(-1, rd, wr, lat);
      check("mask_resp_write", WW'(wr), 32'd1);
      check("mask_resp_rdata_zero", WW'(rd == '0), 32'd1);
      issue(1'b0, AW'(32'h020), '0, '0);
      check("b2b_spacing", WW'(acc_cyc - a1), WW'(BW + 2));
      collect(0, rd, wr, lat);
      for (int i = 0; i < BW; i++)
         check("mask_word", wd(rd, i), (i >= 4 && i <= 7) ? 32'hFFFF_FFFF : 32'hA000_0000 + WW'(i));
      // wrap-around
      for (int i = 0; i < BW; i++) d[i*WW +: WW] = WW'(i);
      issue(1'b1, AW'(32'h1F8), d, '1);
      collect(0, rd, wr, lat);
      issue(1'b0, AW'(32'h000), '0, '0);
      collect(1, rd, wr, lat);
      for (int i = 0; i < 8; i++) check("wrap_word", wd(rd, i), WW'(i + 8));
      // backpressure with the next request already waiting
      issue(1'b0, AW'(32'h020), '0, '0);
      req_write = 1'b0; req_addr = AW'(32'h1F8); req_wdata = '0; req_wmask = '0; req_valid = 1'b1;
      collect(10, rd, wr, lat);
      check("bp_word5", wd(rd, 5), 32'hFFFF_FFFF);
      check("bp_word9", wd(rd, 9), 32'hA000_0009);
      issue(1'b0, AW'(32'h1F8), '0, '0);
      check("bp_next_accept", WW'(acc_cyc - hs_cyc), 32'd1);
      collect(0, rd, wr, lat);
      check("bp2_word3", wd(rd, 3), 32'd3);
      check("bp2_word8", wd(rd, 8), 32'd8);
      // reset in the middle of a write
      for (int i = 0; i < BW; i++) d[i*WW +: WW] = 32'h1234_0000 + WW'(i);
      issue(1'b1, AW'(32'h100), d, '1);
      collect(0, rd, wr, lat);
      for (int i = 0; i < BW; i++) d[i*WW +: WW] = 32'h5555_5555;
      issue(1'b1, AW'(32'h100), d, '1);
      repeat (5) @(posedge clk);
      @(negedge clk); #1;
      rst = 1'b1;
      #1;
      check("rst_async_valid", WW'(resp_valid), 32'd0);
      check("rst_async_ready", WW'(req_ready), 32'd1);
      repeat (2) @(negedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      issue(1'b0, AW'(32'h100), '0, '0);
      collect(0, rd, wr, lat);
      for (int i = 0; i < BW; i++)
         check("rst_mid_word", wd(rd, i), (i < 5) ? 32'h5555_5555 : 32'h1234_0000 + WW'(i));
`endif
      // random traffic
      for (int t = 0; t < 60; t++) begin
         g = $urandom_range(0, 2);
         repeat (g) begin @(posedge clk); #1; end
         for (int i = 0; i < BW; i++) d[i*WW +: WW] = $urandom;
         if (INIT_EN) n = $urandom_range(0, DEPTH - 1);
         else n = (DEPTH - 8 + $urandom_range(0, 24)) % DEPTH;
         issue(1'($urandom_range(0, 1)), AW'(n), d, BW'($urandom));
         collect($urandom_range(0, 4) - 1, rd, wr, lat);
         check("rand_latency", WW'(lat), WW'(BW));
      end
      repeat (2) @(posedge clk);
      finish_run();
   end
endmodule
